// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator and pixel output stage.
//
// A free-running hc/vc raster counter drives a combinational pixel-address
// request to the frame-buffer/sprite compositor. The raster flags
// (sync, active, line/frame strobe) for that request go through a FETCH_LAT-deep
// shift pipe, so that they meet the returned colour. A single output register then
// drives every pin, which keeps all outputs mutually aligned at FETCH_LAT+1 cycles
// after the request.
//
// Ports:
//   pclk        in   pixel clock
//   reset       in   synchronous, active-high reset
//   vga_data    in   12-bit {R,G,B} for the address issued FETCH_LAT cycles earlier
//   blank_rgb   in   colour driven outside the active area
//   h_addr      out  active-area column request (0 when not active)
//   v_addr      out  active-area row request (0 when not active)
//   req_valid   out  h_addr/v_addr is an in-frame request this cycle
//   hsync/vsync out  registered syncs, asserted level set by H/V_SYNC_POL
//   de          out  registered data enable, aligned with vga_r/g/b
//   vga_r/g/b   out  registered 4-bit colour channels
//   frame_start out  one-cycle pulse at the output stage for hc=0, vc=0
//   line_start  out  one-cycle pulse at the output stage for each hc=0
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned FETCH_LAT  = 0,
  parameter int unsigned CW         = 11
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic [11:0]   vga_data,
  input  logic [11:0]   blank_rgb,
  output logic [CW-1:0] h_addr,
  output logic [CW-1:0] v_addr,
  output logic          req_valid,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          frame_start,
  output logic          line_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;

  localparam logic [CW-1:0] HTotM1  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VTotM1  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HStart  = CW'(H_START);
  localparam logic [CW-1:0] VStart  = CW'(V_START);
  localparam logic [CW-1:0] HEnd    = CW'(H_START + H_ACTIVE);
  localparam logic [CW-1:0] VEnd    = CW'(V_START + V_ACTIVE);
  localparam logic [CW-1:0] HSyncW  = CW'(H_SYNC);
  localparam logic [CW-1:0] VSyncW  = CW'(V_SYNC);

  // Flag vector layout, carried through the delay pipe as one word.
  localparam int unsigned FlHs    = 0;
  localparam int unsigned FlVs    = 1;
  localparam int unsigned FlAct   = 2;
  localparam int unsigned FlLine  = 3;
  localparam int unsigned FlFrame = 4;
  localparam int unsigned FlW     = 5;

  if (H_SYNC < 1 || H_BP < 1 || H_FP < 1 || V_SYNC < 1 || V_BP < 1 || V_FP < 1 ||
      FETCH_LAT > 7 || CW > 31 || H_TOTAL >= (32'd1 << CW) ||
      V_TOTAL >= (32'd1 << CW)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == HTotM1) begin
      hc_d = '0;
      vc_d = (vc_q == VTotM1) ? '0 : vc_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request stage (combinational from the counters)
  // ---------------------------------------------------------------------------
  logic h_act, v_act, act;

  assign h_act = (hc_q >= HStart) && (hc_q < HEnd);
  assign v_act = (vc_q >= VStart) && (vc_q < VEnd);
  assign act   = h_act && v_act;

  assign req_valid = act;
  assign h_addr    = act ? hc_q - HStart : '0;
  assign v_addr    = act ? vc_q - VStart : '0;

  // Sync flags are "asserted" booleans here; polarity is applied only at the pins,
  // so a cleared pipe stage always reads as not-in-sync.
  logic [FlW-1:0] flags_raw;
  logic [FlW-1:0] flags_dly;

  always_comb begin
    flags_raw          = '0;
    flags_raw[FlHs]    = hc_q < HSyncW;
    flags_raw[FlVs]    = vc_q < VSyncW;
    flags_raw[FlAct]   = act;
    flags_raw[FlLine]  = hc_q == '0;
    flags_raw[FlFrame] = (hc_q == '0) && (vc_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Delay pipe matching the fetch latency of the pixel source
  // ---------------------------------------------------------------------------
  if (FETCH_LAT == 0) begin : g_no_pipe
    assign flags_dly = flags_raw;
  end else begin : g_pipe
    localparam int unsigned PipeW = FlW * FETCH_LAT;
    // Packed shift register: newest stage in the low bits, oldest at the top.
    logic [PipeW-1:0] pipe_q;

    always_ff @(posedge pclk) begin
      if (reset) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= (pipe_q << FlW) | PipeW'(flags_raw);
      end
    end

    assign flags_dly = pipe_q[PipeW-1 -: FlW];
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic        de_q, de_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_q, frame_d;
  logic        line_q, line_d;

  always_comb begin
    de_d    = flags_dly[FlAct];
    rgb_d   = flags_dly[FlAct] ? vga_data : blank_rgb;
    hsync_d = flags_dly[FlHs] ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d = flags_dly[FlVs] ? V_SYNC_POL : ~V_SYNC_POL;
    frame_d = flags_dly[FlFrame];
    line_d  = flags_dly[FlLine];
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      de_q    <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      frame_q <= frame_d;
      line_q  <= line_d;
    end
  end

  assign de          = de_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_q;
  assign line_start  = line_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances on a small geometry
// (H 2/3/8/2, V 1/2/4/1 -> 15 x 8 = 120 cycles per frame).
//   inst A: FETCH_LAT=0, active-low syncs, random pixel data and blank colour.
//   inst B: FETCH_LAT=2, active-high syncs, blank 0x00F, a frame buffer returning
//           {h_addr[3:0], v_addr[3:0], 4'h0} two cycles after each request.
// A raster-position model (age since reset, position in frame) predicts every
// output on every cycle; frame/line periods and per-frame counts are pinned with
// hand-computed literals.
module tb_vga_timing_gen;

  localparam int HSY = 2, HBP = 3, HAC = 8, HFP = 2;
  localparam int VSY = 1, VBP = 2, VAC = 4, VFP = 1;
  localparam int HT  = HSY + HBP + HAC + HFP;
  localparam int VT  = VSY + VBP + VAC + VFP;
  localparam int TOT = HT * VT;
  localparam int CW  = 11;
  localparam int LAT_A = 0;
  localparam int LAT_B = 2;

  logic pclk = 1'b0;
  logic reset;
  logic [11:0] data_a, data_b, blank_a, blank_b;

  logic [CW-1:0] ha_a, va_a, ha_b, va_b;
  logic rv_a, hs_a, vs_a, de_a, fs_a, ls_a;
  logic rv_b, hs_b, vs_b, de_b, fs_b, ls_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

  always #5 pclk = ~pclk;

  vga_timing_gen #(
    .H_ACTIVE(HAC), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VAC), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .FETCH_LAT(LAT_A), .CW(CW)
  ) u_dut_a (
    .pclk(pclk), .reset(reset), .vga_data(data_a), .blank_rgb(blank_a),
    .h_addr(ha_a), .v_addr(va_a), .req_valid(rv_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .frame_start(fs_a), .line_start(ls_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HAC), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VAC), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .FETCH_LAT(LAT_B), .CW(CW)
  ) u_dut_b (
    .pclk(pclk), .reset(reset), .vga_data(data_b), .blank_rgb(blank_b),
    .h_addr(ha_b), .v_addr(va_b), .req_valid(rv_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .frame_start(fs_b), .line_start(ls_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: position in the frame of the current request, cycles since reset.
  int mdl_pos   = 0;
  int mdl_age   = 0;
  bit mdl_valid = 1'b0;

  // Per-instance statistics for the literal period/count checks.
  int last_fs [2];
  int last_ls [2];
  int de_cnt  [2];
  int hs_cnt  [2];
  int vs_cnt  [2];
  bit fresh   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int hc_of(input int p); return p % HT; endfunction
  function automatic int vc_of(input int p); return p / HT; endfunction
  function automatic bit act_of(input int p);
    return hc_of(p) >= HSY + HBP && hc_of(p) < HSY + HBP + HAC &&
           vc_of(p) >= VSY + VBP && vc_of(p) < VSY + VBP + VAC;
  endfunction

  task automatic check_inst(input int inst, input string pfx, input int lat,
                            input bit hpol, input bit vpol,
                            input logic [11:0] dprev, input logic [11:0] bprev,
                            input logic [CW-1:0] ha, input logic [CW-1:0] va,
                            input logic rv, input logic hs, input logic vs,
                            input logic de, input logic [11:0] rgb,
                            input logic fs, input logic ls);
    bit          e_act, e_de, e_hs, e_vs, e_fs, e_ls;
    logic [11:0] e_rgb;
    int          rp;
    e_act = act_of(mdl_pos);
    check({pfx, "_req_valid"}, rv, e_act);
    check({pfx, "_h_addr"}, ha, e_act ? hc_of(mdl_pos) - (HSY + HBP) : 0);
    check({pfx, "_v_addr"}, va, e_act ? vc_of(mdl_pos) - (VSY + VBP) : 0);

    e_de = 1'b0; e_rgb = 12'h000; e_hs = ~hpol; e_vs = ~vpol; e_fs = 1'b0; e_ls = 1'b0;
    if (mdl_age >= 1 && mdl_age <= lat) begin
      e_rgb = bprev;
    end else if (mdl_age >= lat + 1) begin
      rp    = (mdl_pos - 1 - lat + TOT) % TOT;
      e_de  = act_of(rp);
      e_rgb = e_de ? dprev : bprev;
      e_hs  = (hc_of(rp) < HSY) ? hpol : ~hpol;
      e_vs  = (vc_of(rp) < VSY) ? vpol : ~vpol;
      e_fs  = rp == 0;
      e_ls  = hc_of(rp) == 0;
      if (inst == 1 && e_de)
        check({pfx, "_pixel_coord"}, rgb,
              {4'(hc_of(rp) - (HSY + HBP)), 4'(vc_of(rp) - (VSY + VBP)), 4'h0});
    end
    check({pfx, "_de"}, de, e_de);
    check({pfx, "_rgb"}, rgb, e_rgb);
    check({pfx, "_hsync"}, hs, e_hs);
    check({pfx, "_vsync"}, vs, e_vs);
    check({pfx, "_frame_start"}, fs, e_fs);
    check({pfx, "_line_start"}, ls, e_ls);

    // Literal expectations for this geometry: 120-cycle frames, 15-cycle lines,
    // 32 de cycles, 2x8 hsync cycles and one 15-cycle vsync line per frame.
    if (fs === 1'b1) begin
      if (fresh[inst]) begin
        check({pfx, "_first_frame_age"}, mdl_age, lat + 1);
        fresh[inst] = 1'b0;
      end else if (last_fs[inst] >= 0) begin
        check({pfx, "_frame_period"}, cyc - last_fs[inst], 120);
        check({pfx, "_de_per_frame"}, de_cnt[inst], 32);
        check({pfx, "_hsync_per_frame"}, hs_cnt[inst], 16);
        check({pfx, "_vsync_per_frame"}, vs_cnt[inst], 15);
      end
      last_fs[inst] = cyc;
      de_cnt[inst] = 0; hs_cnt[inst] = 0; vs_cnt[inst] = 0;
    end
    if (ls === 1'b1) begin
      if (last_ls[inst] >= 0) check({pfx, "_line_period"}, cyc - last_ls[inst], 15);
      last_ls[inst] = cyc;
    end
    if (de === 1'b1) de_cnt[inst]++;
    if (hs === hpol) hs_cnt[inst]++;
    if (vs === vpol) vs_cnt[inst]++;
  endtask

  // Compare process: capture the inputs the output register sampled, advance the
  // model, then check both instances once the outputs have settled.
  logic        rst_s;
  logic [11:0] dp_a, dp_b, bp_a, bp_b;

  always @(posedge pclk) begin
    rst_s = reset;
    dp_a = data_a; dp_b = data_b; bp_a = blank_a; bp_b = blank_b;
    #2;
    cyc++;
    if (rst_s === 1'b1) begin
      mdl_valid = 1'b1;
      mdl_pos   = 0;
      mdl_age   = 0;
      for (int i = 0; i < 2; i++) begin
        last_fs[i] = -1; last_ls[i] = -1; fresh[i] = 1'b1;
      end
    end else begin
      mdl_pos = (mdl_pos + 1) % TOT;
      mdl_age++;
    end
    if (mdl_valid) begin
      check_inst(0, "A", LAT_A, 1'b0, 1'b0, dp_a, bp_a, ha_a, va_a, rv_a, hs_a, vs_a,
                 de_a, {r_a, g_a, b_a}, fs_a, ls_a);
      check_inst(1, "B", LAT_B, 1'b1, 1'b1, dp_b, bp_b, ha_b, va_b, rv_b, hs_b, vs_b,
                 de_b, {r_b, g_b, b_b}, fs_b, ls_b);
    end
  end

  // Frame buffer model for instance B: returns coordinates LAT_B cycles later.
  logic [2*CW:0] fb_h0, fb_h1, fb_h2;

  task automatic drive_inputs(input bit rst);
    reset   = rst;
    fb_h2   = fb_h1;
    fb_h1   = fb_h0;
    fb_h0   = {rv_b, ha_b, va_b};
    data_a  = 12'($urandom);
    blank_a = 12'($urandom);
    blank_b = 12'h00F;
    if (fb_h2[2*CW])
      data_b = {fb_h2[CW+3:CW], fb_h2[3:0], 4'h0};
    else
      data_b = 12'($urandom);
  endtask

  initial begin
    bit hit;
    reset = 1'b1;
    data_a = '0; data_b = '0; blank_a = '0; blank_b = 12'h00F;
    fb_h0 = '0; fb_h1 = '0; fb_h2 = '0;
    repeat (3) @(posedge pclk);

    // Two and a half undisturbed frames.
    for (int n = 0; n < 300; n++) begin
      @(negedge pclk);
      drive_inputs(1'b0);
    end

    // Reset mid-line at hc=7, vc=4 (position 67) with pixels in flight.
    hit = 1'b0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(negedge pclk);
      hit = mdl_pos == 4 * HT + 7;
      drive_inputs(hit);
    end
    check("mid_reset_reached", hit, 1'b1);

    // Long random run with occasional resets.
    for (int n = 0; n < 1200; n++) begin
      @(negedge pclk);
      drive_inputs($urandom_range(0, 499) == 0);
    end

    @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
